// File: rtl/cnt_seq_checker.sv
// Receive-side checker for a free-running up-counter: locks after LOCK_LEN clean increments, then flags skips/repeats.
// Latency: one cycle, so a sample taken at edge N is visible on every output after edge N.
// Backpressure: none; the checker is a pure sink, and cycles with cnt_vld low simply hold all state.
module cnt_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_vld,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0] expected
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [RUN_W-1:0]   run, run_nxt;
    logic [WIDTH-1:0]   expected_nxt;
    logic [WIDTH-1:0]   cnt_inc;
    logic               match;
    logic               err_pulse_nxt;
    logic               err_inc;
    logic               wrap_inc;

    assign cnt_inc = cnt_in + WIDTH'(1);
    assign match   = (cnt_in == expected);

    always_comb begin
        state_nxt     = state;
        run_nxt       = run;
        expected_nxt  = expected;
        err_pulse_nxt = 1'b0;
        err_inc       = 1'b0;
        wrap_inc      = 1'b0;
        if (cnt_vld) begin
            // Every valid sample re-anchors the expectation, whether it matched or not.
            expected_nxt = cnt_inc;
            unique case (state)
                IDLE: begin
                    run_nxt   = '0;
                    state_nxt = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        run_nxt = run + RUN_W'(1);
                        if (run == RUN_W'(LOCK_LEN - 1)) begin
                            state_nxt = LOCK;
                        end
                    end else begin
                        run_nxt = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        wrap_inc = (cnt_in == '0);
                    end else begin
                        err_pulse_nxt = 1'b1;
                        err_inc       = 1'b1;
                        run_nxt       = '0;
                        state_nxt     = ACQ;
                    end
                end
                default: begin
                    run_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            run       <= '0;
            expected  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            run       <= run_nxt;
            expected  <= expected_nxt;
            locked    <= (state_nxt == LOCK);
            err_pulse <= err_pulse_nxt;
            // Clear takes priority over a coincident statistics event.
            if (clear) begin
                err_cnt  <= '0;
                wrap_cnt <= '0;
            end else begin
                if (err_inc && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (wrap_inc && (wrap_cnt != '1)) begin
                    wrap_cnt <= wrap_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Bench for cnt_seq_checker: directed scenarios plus random traffic against a sequence-level model.
module tb_cnt_seq_checker;

    localparam int LOCK_LEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cnt_in = '0;
    logic        cnt_vld = 1'b0;
    logic        clear = 1'b0;

    logic        locked, err_pulse;
    logic [15:0] err_cnt, wrap_cnt;
    logic [7:0]  expected;
    logic        s_locked, s_err_pulse;
    logic [1:0]  s_err_cnt, s_wrap_cnt;
    logic [7:0]  s_expected;

    int n_chk = 0;
    int n_fail = 0;

    // Sequence-level model: seeded flag, streak of good increments, lock flag, stats.
    bit seeded, in_lock, m_pulse;
    int streak, m_exp, m_err, m_wrap, m_err_s, m_wrap_s;

    always #5 clk = ~clk;

    cnt_seq_checker #(.WIDTH(8), .LOCK_LEN(LOCK_LEN), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
        .expected(expected)
    );

    cnt_seq_checker #(.WIDTH(8), .LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_s (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clear(clear),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .wrap_cnt(s_wrap_cnt),
        .expected(s_expected)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit vld, input int val, input bit clr, input bit rst);
        bit err_ev, wrap_ev;
        err_ev  = 1'b0;
        wrap_ev = 1'b0;
        if (rst) begin
            seeded = 0; in_lock = 0; m_pulse = 0; streak = 0; m_exp = 0;
            m_err = 0; m_wrap = 0; m_err_s = 0; m_wrap_s = 0;
            return;
        end
        m_pulse = 0;
        if (vld) begin
            if (!seeded) begin
                seeded = 1;
                streak = 0;
            end else if (val == m_exp) begin
                if (in_lock) begin
                    wrap_ev = (val == 0);
                end else begin
                    streak++;
                    if (streak == LOCK_LEN) in_lock = 1;
                end
            end else begin
                if (in_lock) begin
                    m_pulse = 1;
                    err_ev  = 1;
                end
                in_lock = 0;
                streak  = 0;
            end
            m_exp = (val + 1) % 256;
        end
        if (clr) begin
            m_err = 0; m_wrap = 0; m_err_s = 0; m_wrap_s = 0;
        end else begin
            if (err_ev && m_err < 65535)  m_err++;
            if (wrap_ev && m_wrap < 65535) m_wrap++;
            if (err_ev && m_err_s < 3)    m_err_s++;
            if (wrap_ev && m_wrap_s < 3)  m_wrap_s++;
        end
    endtask

    task automatic step(input bit vld, input logic [7:0] val, input bit clr, input bit rst);
        @(negedge clk);
        cnt_vld = vld;
        cnt_in  = val;
        clear   = clr;
        reset   = rst;
        @(posedge clk);
        model(vld, int'(val), clr, rst);
        #1;
        check("locked",      locked,      in_lock);
        check("err_pulse",   err_pulse,   m_pulse);
        check("expected",    expected,    m_exp);
        check("err_cnt",     err_cnt,     m_err);
        check("wrap_cnt",    wrap_cnt,    m_wrap);
        check("s_err_cnt",   s_err_cnt,   m_err_s);
        check("s_wrap_cnt",  s_wrap_cnt,  m_wrap_s);
        check("s_locked",    s_locked,    in_lock);
    endtask

    task automatic feed(input logic [7:0] val);
        step(1'b1, val, 1'b0, 1'b0);
    endtask

    // Seed at s, then four clean increments: ends locked with expected s+5.
    task automatic seed_lock(input logic [7:0] s);
        logic [7:0] v;
        v = s;
        for (int i = 0; i <= LOCK_LEN; i++) begin
            feed(v);
            v = v + 8'd1;
        end
    endtask

    initial begin
        logic [7:0] cur, v;
        int r;

        // Scenario 1: lock acquisition
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_locked", locked, 0);
        check("rst_expected", expected, 0);
        check("rst_err_cnt", err_cnt, 0);
        for (int i = 'h10; i <= 'h13; i++) feed(8'(i));
        check("s1_unlocked_at_13", locked, 0);
        feed(8'h14);
        check("s1_locked_at_14", locked, 1);
        check("s1_expected", expected, 8'h15);

        // Scenario 2: wrap through zero
        for (int i = 'h15; i <= 'hFF; i++) feed(8'(i));
        feed(8'h00);
        check("s2_wrap_cnt", wrap_cnt, 1);
        check("s2_locked", locked, 1);
        feed(8'h01);
        check("s2_expected", expected, 8'h02);

        // Scenario 3: skip error and relock
        for (int i = 'h02; i <= 'h1F; i++) feed(8'(i));
        check("s3_expected_20", expected, 8'h20);
        feed(8'h22);
        check("s3_err_pulse", err_pulse, 1);
        check("s3_err_cnt", err_cnt, 1);
        check("s3_unlocked", locked, 0);
        check("s3_expected_23", expected, 8'h23);
        feed(8'h23);
        check("s3_pulse_once", err_pulse, 0);
        feed(8'h24); feed(8'h25);
        check("s3_not_yet", locked, 0);
        feed(8'h26);
        check("s3_relocked", locked, 1);

        // Scenario 4: valid gaps carrying garbage
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 'h10; i <= 'h14; i++) begin
            feed(8'(i));
            r = $urandom_range(1, 2);
            for (int g = 0; g < r; g++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        end
        check("s4_locked", locked, 1);
        check("s4_expected", expected, 8'h15);

        // Scenario 5: build err=3 wrap=2, then clear
        seed_lock(8'hF0);
        for (int i = 'hF5; i <= 'hFF; i++) feed(8'(i));
        feed(8'h00);
        seed_lock(8'h80);
        seed_lock(8'h10);
        for (int i = 'h15; i <= 'hFF; i++) feed(8'(i));
        feed(8'h00);
        check("s5_err_3", err_cnt, 3);
        check("s5_wrap_2", wrap_cnt, 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("s5_clr_err", err_cnt, 0);
        check("s5_clr_wrap", wrap_cnt, 0);
        check("s5_clr_locked", locked, 1);
        step(1'b1, 8'h50, 1'b1, 1'b0);
        check("s5_clr_pulse", err_pulse, 1);
        check("s5_clr_wins", err_cnt, 0);
        check("s5_clr_unlock", locked, 0);

        // Scenario 6: reset mid-lock, then saturation of the 2-bit counter
        seed_lock(8'h60);
        step(1'b1, 8'h65, 1'b0, 1'b1);
        check("s6_rst_locked", locked, 0);
        check("s6_rst_expected", expected, 0);
        feed(8'h80);
        check("s6_seed_expected", expected, 8'h81);
        for (int i = 'h81; i <= 'h84; i++) feed(8'(i));
        for (int k = 0; k < 5; k++) seed_lock(expected + 8'h40);
        check("s6_sat_err", s_err_cnt, 3);
        check("s6_wide_err", err_cnt, 5);

        // Random traffic: increments with occasional skips, repeats, jumps, gaps, clears, resets
        cur = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            bit vld, clr, rst;
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 63) == 0);
            vld = ($urandom_range(0, 3) != 0);
            if (vld) begin
                r = $urandom_range(0, 19);
                if (r == 0)      v = 8'($urandom);
                else if (r == 1) v = cur;
                else if (r == 2) v = cur + 8'd2;
                else             v = cur + 8'd1;
                cur = v;
            end else begin
                v = 8'($urandom);
            end
            step(vld, v, clr, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
